// File: rtl/m92_pkg.sv
// Shared types and helpers for the V33 CPU SDRAM responder.
package m92_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SDR_WAIT = 2'd1,
    RELEASE  = 2'd2
  } responder_state_t;

  // Width of a 16-bit word address within the 25-bit SDRAM byte space.
  localparam int unsigned SDR_WORD_AW = 24;

  // Replace the bytes of old_word selected by be with those of new_word.
  function automatic logic [15:0] byte_merge(input logic [15:0] old_word,
                                             input logic [15:0] new_word,
                                             input logic [1:0]  be);
    logic [15:0] merged;
    merged       = old_word;
    if (be[0]) merged[7:0]  = new_word[7:0];
    if (be[1]) merged[15:8] = new_word[15:8];
    return merged;
  endfunction

endpackage

// File: rtl/cpu_sdr_responder_if.sv
// CPU bus and SDRAM arbiter signals seen by the SDRAM responder.
interface cpu_sdr_responder_if;
  // CPU side and address translator
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_dout;
  logic        ram_rom_memrq;
  logic        writable;
  logic [24:0] sdr_addr;
  logic [15:0] cpu_din;
  logic        cpu_ready;
  logic        write_blocked;
  // SDRAM arbiter side
  logic        sdr_req;
  logic        sdr_ack;
  logic        sdr_we;
  logic [24:0] sdr_req_addr;
  logic [15:0] sdr_wdata;
  logic [1:0]  sdr_be;
  logic [15:0] sdr_rdata;

  // The responder
  modport slave (
    input  mem_rd, mem_wr, cpu_be, cpu_dout, ram_rom_memrq, writable, sdr_addr,
    input  sdr_ack, sdr_rdata,
    output cpu_din, cpu_ready, write_blocked,
    output sdr_req, sdr_we, sdr_req_addr, sdr_wdata, sdr_be
  );

  // CPU bus plus arbiter, as seen from outside the responder
  modport master (
    output mem_rd, mem_wr, cpu_be, cpu_dout, ram_rom_memrq, writable, sdr_addr,
    output sdr_ack, sdr_rdata,
    input  cpu_din, cpu_ready, write_blocked,
    input  sdr_req, sdr_we, sdr_req_addr, sdr_wdata, sdr_be
  );
endinterface

// File: rtl/cpu_word_cache.sv
// Single-word read cache with byte-enabled write-through update.
module cpu_word_cache
  import m92_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [SDR_WORD_AW-1:0] lookup_tag,
  output logic                   hit,
  output logic [15:0]            rd_data,
  input  logic                   fill_en,
  input  logic [SDR_WORD_AW-1:0] fill_tag,
  input  logic [15:0]            fill_data,
  input  logic                   upd_en,
  input  logic [SDR_WORD_AW-1:0] upd_tag,
  input  logic [1:0]             upd_be,
  input  logic [15:0]            upd_data
);

  logic                   valid_q;
  logic [SDR_WORD_AW-1:0] tag_q;
  logic [15:0]            data_q;

  // Fill on read completion; merge write bytes only into a matching valid line.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en && CACHE_EN) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag;
      data_q  <= fill_data;
    end else if (upd_en && valid_q && (tag_q == upd_tag)) begin
      data_q  <= byte_merge(data_q, upd_data, upd_be);
    end
  end

  // Lookup is combinational so the responder can answer in the cycle after accept.
  always_comb begin
    hit     = CACHE_EN && valid_q && (tag_q == lookup_tag);
    rd_data = data_q;
  end

endmodule

// File: rtl/cpu_sdr_responder.sv
// Services SDRAM-decoded V33 bus cycles via a toggle handshake to the arbiter.
module cpu_sdr_responder
  import m92_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                clk_sys,
  input  logic                reset,
  cpu_sdr_responder_if.slave  bus
);

  responder_state_t state_q;

  logic [15:0] cpu_din_q;
  logic        cpu_ready_q;
  logic        write_blocked_q;
  logic        sdr_req_q;
  logic        sdr_we_q;
  logic [24:0] sdr_req_addr_q;
  logic [15:0] sdr_wdata_q;
  logic [1:0]  sdr_be_q;

  logic        req_fire;
  logic        ack_match;
  logic        sdr_done;
  logic        cache_hit;
  logic [15:0] cache_data;
  logic        unused_addr_lsb;

  // Byte address bit 0 is irrelevant to 16-bit word accesses.
  assign unused_addr_lsb = bus.sdr_addr[0];

  // Request qualification and handshake completion.
  always_comb begin
    req_fire  = (bus.mem_rd | bus.mem_wr) & bus.ram_rom_memrq;
    ack_match = (bus.sdr_ack == sdr_req_q);
    sdr_done  = (state_q == SDR_WAIT) && ack_match;
  end

  cpu_word_cache #(
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .lookup_tag (bus.sdr_addr[24:1]),
    .hit        (cache_hit),
    .rd_data    (cache_data),
    .fill_en    (sdr_done && !sdr_we_q),
    .fill_tag   (sdr_req_addr_q[24:1]),
    .fill_data  (bus.sdr_rdata),
    .upd_en     (sdr_done && sdr_we_q),
    .upd_tag    (sdr_req_addr_q[24:1]),
    .upd_be     (sdr_be_q),
    .upd_data   (sdr_wdata_q)
  );

  // Transaction FSM: accept in IDLE, wait for ack, hold until strobes drop.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q         <= IDLE;
      cpu_din_q       <= '0;
      cpu_ready_q     <= 1'b0;
      write_blocked_q <= 1'b0;
      sdr_req_q       <= 1'b0;
      sdr_we_q        <= 1'b0;
      sdr_req_addr_q  <= '0;
      sdr_wdata_q     <= '0;
      sdr_be_q        <= '0;
    end else begin
      cpu_ready_q     <= 1'b0;
      write_blocked_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            if (bus.mem_wr && !bus.writable) begin
              cpu_ready_q     <= 1'b1;
              write_blocked_q <= 1'b1;
              state_q         <= RELEASE;
            end else if (!bus.mem_wr && cache_hit) begin
              cpu_din_q   <= cache_data;
              cpu_ready_q <= 1'b1;
              state_q     <= RELEASE;
            end else begin
              sdr_req_addr_q <= {bus.sdr_addr[24:1], 1'b0};
              sdr_we_q       <= bus.mem_wr;
              sdr_wdata_q    <= bus.cpu_dout;
              sdr_be_q       <= bus.mem_wr ? bus.cpu_be : 2'b11;
              sdr_req_q      <= ~sdr_req_q;
              state_q        <= SDR_WAIT;
            end
          end
        end
        SDR_WAIT: begin
          if (ack_match) begin
            cpu_ready_q <= 1'b1;
            if (!sdr_we_q) cpu_din_q <= bus.sdr_rdata;
            state_q     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!bus.mem_rd && !bus.mem_wr) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_din       = cpu_din_q;
  assign bus.cpu_ready     = cpu_ready_q;
  assign bus.write_blocked = write_blocked_q;
  assign bus.sdr_req       = sdr_req_q;
  assign bus.sdr_we        = sdr_we_q;
  assign bus.sdr_req_addr  = sdr_req_addr_q;
  assign bus.sdr_wdata     = sdr_wdata_q;
  assign bus.sdr_be        = sdr_be_q;

endmodule

// File: tb/tb_cpu_sdr_responder.sv
// Directed bench for cpu_sdr_responder with a toggle-handshake arbiter model.
module tb_cpu_sdr_responder;

  logic clk_sys;
  logic reset;

  cpu_sdr_responder_if bus ();

  cpu_sdr_responder #(
    .CACHE_EN (1'b1)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Arbiter model controls
  int          arb_delay = 3;
  int          arb_cnt   = 0;
  logic [15:0] arb_rdata = '0;

  // Event counters
  int   ready_cnt = 0;
  int   blk_cnt   = 0;
  int   tog_cnt   = 0;
  logic prev_req  = 1'b0;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  assign bus.sdr_rdata = arb_rdata;

  // Acknowledge arb_delay cycles after the request toggle is seen.
  always @(posedge clk_sys) begin
    if (reset) begin
      bus.sdr_ack <= 1'b0;
      arb_cnt     <= 0;
    end else if (bus.sdr_req != bus.sdr_ack) begin
      if (arb_cnt >= arb_delay - 1) begin
        bus.sdr_ack <= bus.sdr_req;
        arb_cnt     <= 0;
      end else begin
        arb_cnt <= arb_cnt + 1;
      end
    end
  end

  // Count ready/blocked pulses and request toggles.
  always @(posedge clk_sys) begin
    if (bus.cpu_ready)        ready_cnt <= ready_cnt + 1;
    if (bus.write_blocked)    blk_cnt   <= blk_cnt + 1;
    if (bus.sdr_req != prev_req) tog_cnt <= tog_cnt + 1;
    prev_req <= bus.sdr_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [24:0] addr,
                        input logic [1:0] be, input logic [15:0] dout,
                        input logic wrt, output int lat);
    bus.mem_rd        = rd;
    bus.mem_wr        = wr;
    bus.sdr_addr      = addr;
    bus.cpu_be        = be;
    bus.cpu_dout      = dout;
    bus.writable      = wrt;
    bus.ram_rom_memrq = 1'b1;
    lat = 0;
    do begin
      @(negedge clk_sys);
      lat++;
    end while (!bus.cpu_ready && lat < 50);
  endtask

  task automatic release_bus();
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_din"},   {16'h0, bus.cpu_din},        32'h0);
    check({tag, "_rdy"},   {31'h0, bus.cpu_ready},      32'h0);
    check({tag, "_blk"},   {31'h0, bus.write_blocked},  32'h0);
    check({tag, "_req"},   {31'h0, bus.sdr_req},        32'h0);
    check({tag, "_we"},    {31'h0, bus.sdr_we},         32'h0);
    check({tag, "_addr"},  {7'h0, bus.sdr_req_addr},    32'h0);
    check({tag, "_wdata"}, {16'h0, bus.sdr_wdata},      32'h0);
    check({tag, "_be"},    {30'h0, bus.sdr_be},         32'h0);
  endtask

  initial begin
    int lat;
    int t0;
    int r0;
    int b0;

    reset             = 1'b1;
    bus.mem_rd        = 1'b0;
    bus.mem_wr        = 1'b0;
    bus.cpu_be        = 2'b00;
    bus.cpu_dout      = '0;
    bus.ram_rom_memrq = 1'b0;
    bus.writable      = 1'b0;
    bus.sdr_addr      = '0;
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk_sys);

    // Read miss: ack 3 cycles after toggle, ready 5 negedges after request.
    arb_rdata = 16'hBEEF;
    t0 = tog_cnt;
    access(1'b1, 1'b0, 25'h0012344, 2'b01, 16'h0, 1'b1, lat);
    check("miss_lat",   lat,                  5);
    check("miss_din",   bus.cpu_din,          16'hBEEF);
    check("miss_addr",  bus.sdr_req_addr,     25'h0012344);
    check("miss_be",    bus.sdr_be,           2'b11);
    check("miss_we",    bus.sdr_we,           1'b0);
    check("miss_tog",   tog_cnt - t0,         1);
    @(negedge clk_sys);
    check("miss_pulse", bus.cpu_ready,        1'b0);
    release_bus();

    // Same read again: cache hit at T+1, no SDRAM request.
    arb_rdata = 16'h0000;
    t0 = tog_cnt;
    access(1'b1, 1'b0, 25'h0012344, 2'b11, 16'h0, 1'b1, lat);
    check("hit_lat", lat,          1);
    check("hit_din", bus.cpu_din,  16'hBEEF);
    check("hit_tog", tog_cnt - t0, 0);
    release_bus();

    // Write high byte to writable target, odd byte address.
    t0 = tog_cnt;
    access(1'b0, 1'b1, 25'h0012345, 2'b10, 16'h12AB, 1'b1, lat);
    check("wr_lat",   lat,              5);
    check("wr_we",    bus.sdr_we,       1'b1);
    check("wr_be",    bus.sdr_be,       2'b10);
    check("wr_addr",  bus.sdr_req_addr, 25'h0012344);
    check("wr_wdata", bus.sdr_wdata,    16'h12AB);
    check("wr_din",   bus.cpu_din,      16'hBEEF);
    check("wr_tog",   tog_cnt - t0,     1);
    release_bus();

    // Read after write-through hits merged word.
    t0 = tog_cnt;
    access(1'b1, 1'b0, 25'h0012344, 2'b11, 16'h0, 1'b1, lat);
    check("merge_lat", lat,          1);
    check("merge_din", bus.cpu_din,  16'h12EF);
    check("merge_tog", tog_cnt - t0, 0);
    release_bus();

    // Blocked write: ready and write_blocked together at T+1, cache untouched.
    t0 = tog_cnt;
    b0 = blk_cnt;
    access(1'b0, 1'b1, 25'h0012344, 2'b11, 16'h5555, 1'b0, lat);
    check("blk_lat",   lat,               1);
    check("blk_flag",  bus.write_blocked, 1'b1);
    @(negedge clk_sys);
    check("blk_pulse", bus.write_blocked, 1'b0);
    check("blk_cnt",   blk_cnt - b0,      1);
    check("blk_tog",   tog_cnt - t0,      0);
    release_bus();
    access(1'b1, 1'b0, 25'h0012344, 2'b11, 16'h0, 1'b1, lat);
    check("blk_cache_lat", lat,         1);
    check("blk_cache_din", bus.cpu_din, 16'h12EF);
    release_bus();

    // Strobe held past ready: no second request or ready.
    arb_rdata = 16'h1111;
    access(1'b1, 1'b0, 25'h0000100, 2'b11, 16'h0, 1'b1, lat);
    check("hold_lat", lat,         5);
    check("hold_din", bus.cpu_din, 16'h1111);
    @(negedge clk_sys);
    t0 = tog_cnt;
    r0 = ready_cnt;
    repeat (5) @(negedge clk_sys);
    check("hold_tog", tog_cnt - t0,   0);
    check("hold_rdy", ready_cnt - r0, 0);
    release_bus();
    access(1'b1, 1'b0, 25'h0000100, 2'b11, 16'h0, 1'b1, lat);
    check("hold_after_lat", lat, 1);
    release_bus();

    // Reset during SDR_WAIT.
    arb_delay = 10;
    t0 = tog_cnt;
    bus.mem_rd        = 1'b1;
    bus.sdr_addr      = 25'h0000200;
    bus.ram_rom_memrq = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rst_wait_tog", tog_cnt - t0, 1);
    reset      = 1'b1;
    bus.mem_rd = 1'b0;
    @(negedge clk_sys);
    check_all_zero("midrst");
    reset     = 1'b0;
    arb_delay = 3;
    arb_rdata = 16'h7777;
    @(negedge clk_sys);
    t0 = tog_cnt;
    access(1'b1, 1'b0, 25'h0012344, 2'b11, 16'h0, 1'b1, lat);
    check("postrst_lat", lat,          5);
    check("postrst_din", bus.cpu_din,  16'h7777);
    check("postrst_tog", tog_cnt - t0, 1);
    release_bus();

    // Not an SDRAM access: responder stays silent.
    t0 = tog_cnt;
    r0 = ready_cnt;
    bus.ram_rom_memrq = 1'b0;
    bus.mem_rd        = 1'b1;
    bus.sdr_addr      = 25'h0012344;
    repeat (20) @(negedge clk_sys);
    check("nomrq_rdy", ready_cnt - r0, 0);
    check("nomrq_tog", tog_cnt - t0,   0);
    bus.mem_rd = 1'b0;
    @(negedge clk_sys);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_sdr_responder.md
Name: cpu_sdr_responder

Overview:
- Services V33 CPU bus cycles that the address translator has decoded as ram_rom_memrq.
- Converts each qualified read or write into a toggle-handshake request to the SDRAM arbiter.
- Returns read data and a one-cycle ready pulse to the CPU bus.
- Holds a single-word read cache so that repeated fetches from the same word skip SDRAM.
- Drops writes to non-writable (ROM) space internally, without an SDRAM cycle.

Parameters:
- CACHE_EN, 1: 1 enables the single-word read cache; 0 sends every read to SDRAM.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_rd  in  1  CPU read strobe; level, held until the cycle after cpu_ready.
- mem_wr  in  1  CPU write strobe; level, same rules as mem_rd.
- cpu_be  in  2  byte enables; [0] = low byte, [1] = high byte.
- cpu_dout  in  16  CPU write data.
- ram_rom_memrq  in  1  from the address translator: the access targets SDRAM.
- writable  in  1  from the address translator: the target accepts writes.
- sdr_addr  in  25  from the address translator: SDRAM byte address.
- cpu_din  out  16  read data to the CPU.
- cpu_ready  out  1  one-cycle completion pulse.
- sdr_req  out  1  request toggle.
- sdr_ack  in  1  acknowledge toggle; the request is complete when sdr_ack == sdr_req.
- sdr_we  out  1  1 = write.
- sdr_req_addr  out  25  latched byte address; bit 0 is always 0.
- sdr_wdata  out  16  latched write data.
- sdr_be  out  2  latched byte enables.
- sdr_rdata  in  16  read data; valid in the cycle sdr_ack matches sdr_req.
- write_blocked  out  1  one-cycle pulse when a write to a non-writable target is dropped.

Behaviour:
- Reset values: every output is 0. FSM goes to IDLE; cache_valid = 0.
- Reset mid-transaction aborts the FSM and clears sdr_req. The arbiter shares the same reset, so sdr_ack is also 0 after reset.
- FSM states: IDLE, SDR_WAIT, RELEASE.
- IDLE, no request: if (mem_rd | mem_wr) == 0 or ram_rom_memrq == 0, stay in IDLE and drive nothing. Other responders own non-SDRAM accesses.
- IDLE, request accepted at cycle T: fires when (mem_rd | mem_wr) & ram_rom_memrq. If both strobes are high, the write takes priority.
- Blocked write: mem_wr with writable == 0.
  - cpu_ready = 1 and write_blocked = 1 at T+1.
  - No SDRAM request is issued; goes to RELEASE.
- Read cache hit: CACHE_EN, cache_valid, and cache_tag == sdr_addr[24:1].
  - cpu_din = cache_data and cpu_ready = 1 at T+1.
  - Goes to RELEASE.
- SDRAM access (read miss, or write to a writable target):
  - At T+1, latch sdr_req_addr = {sdr_addr[24:1], 1'b0}, sdr_we, sdr_wdata, sdr_be (reads force sdr_be = 2'b11).
  - Toggle sdr_req at T+1; go to SDR_WAIT.
- SDR_WAIT:
  - Wait for the first cycle A in which sdr_ack == sdr_req.
  - At A+1: cpu_ready = 1. A read also latches cpu_din = sdr_rdata and fills the cache (tag and data, cache_valid = 1).
  - Goes to RELEASE.
  - Minimum miss latency is ready at T+2, when ack returns in the same cycle as the toggle. There is no timeout.
- Writes and the cache: a write that reaches SDRAM and whose word tag matches the cache updates only the cached bytes selected by cpu_be (write-through). The cache stays valid.
- Blocked writes never touch the cache.
- cpu_din on a write completion: holds its previous value.
- RELEASE: stays until mem_rd == 0 and mem_wr == 0, then goes to IDLE. A strobe held high past ready therefore never starts a second access.
- cpu_ready and write_blocked are high for exactly one cycle per transaction.
- Address and strobe inputs are sampled only in IDLE. Changes while in SDR_WAIT are ignored.
- sdr_req toggles exactly once per SDRAM transaction.

Decomposition:
- m92_pkg gets:
  - responder_state_t enum {IDLE, SDR_WAIT, RELEASE};
  - SDR_WORD_AW = 24 (the cache tag width).
- The cache (tag, data, valid, byte-merge) is a natural sub-module: cpu_word_cache. Its ports are lookup address, hit, read data, fill, and byte-enabled update.
- The FSM stays in cpu_sdr_responder.

Test Plan:
- Read miss: mem_rd=1, ram_rom_memrq=1, sdr_addr=25'h0012344; arbiter acks 3 cycles after the toggle with 16'hBEEF -> sdr_req toggles once, sdr_req_addr=25'h0012344, sdr_be=2'b11, cpu_ready pulses once with cpu_din=16'hBEEF.
- Repeat the same read after the strobe drops -> cpu_ready at T+1 with 16'hBEEF, sdr_req unchanged.
- Write to a writable target: writable=1, sdr_addr=25'h0012345, cpu_be=2'b10, cpu_dout=16'h12xx -> sdr_we=1, sdr_be=2'b10, sdr_req_addr=25'h0012344. A following read hits the cache and returns 16'h12EF.
- Write with writable=0 -> write_blocked and cpu_ready pulse together at T+1, no sdr_req toggle, cache unchanged.
- mem_rd held high for 5 cycles after cpu_ready -> no second request; the FSM stays in RELEASE until the strobe drops.
- Assert reset during SDR_WAIT -> all outputs 0 next cycle, FSM in IDLE, cache invalid. The next read of 25'h0012344 misses.
- ram_rom_memrq=0 with mem_rd=1 -> no ready and no request for 20 cycles.
